// File: rtl/operand_fetch_if.sv
// Bundle of request, register-file, write-back and operand handshake signals
// for operand_fetch. slave is the block; master is its surrounding pipeline.
interface operand_fetch_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              busy;

    modport slave (
        input  req_valid, rs_addr, rt_addr, rf_rdata,
               wb_en, wb_addr, wb_data, op_ready,
        output req_ready, rf_raddr, op_valid, op_a, op_b, busy
    );

    modport master (
        output req_valid, rs_addr, rt_addr, rf_rdata,
               wb_en, wb_addr, wb_data, op_ready,
        input  req_ready, rf_raddr, op_valid, op_a, op_b, busy
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: reads rs then rt through one register-file port, applies
// write-back bypass/refresh, and holds both operands until execute accepts.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    operand_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] rs_q;
    logic [ADDR_W-1:0] rt_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic [ADDR_W-1:0] rf_raddr_q;
    logic              op_valid_q;
    logic              req_ready_q;
    logic              busy_q;

    logic              hit_rs;
    logic              hit_rt;
    logic [DATA_W-1:0] cap_rs;
    logic [DATA_W-1:0] cap_rt;

    // A write to r0 never hits, so operands sourced from r0 stay zero.
    assign hit_rs = bus.wb_en && (rs_q != '0) && (bus.wb_addr == rs_q);
    assign hit_rt = bus.wb_en && (rt_q != '0) && (bus.wb_addr == rt_q);

    assign cap_rs = (rs_q == '0) ? '0 : (hit_rs ? bus.wb_data : bus.rf_rdata);
    assign cap_rt = (rt_q == '0) ? '0 : (hit_rt ? bus.wb_data : bus.rf_rdata);

    // Status outputs are registered copies that change only with the state,
    // so they are pure functions of the state seen by the next stage.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state       <= IDLE;
            rs_q        <= '0;
            rt_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rf_raddr_q  <= '0;
            op_valid_q  <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        rs_q        <= bus.rs_addr;
                        rt_q        <= bus.rt_addr;
                        rf_raddr_q  <= bus.rs_addr;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= RD_A;
                    end
                end
                RD_A: begin
                    op_a_q     <= cap_rs;
                    rf_raddr_q <= rt_q;
                    state      <= RD_B;
                end
                RD_B: begin
                    op_b_q     <= cap_rt;
                    if (hit_rs) op_a_q <= bus.wb_data;
                    rf_raddr_q <= '0;
                    op_valid_q <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (hit_rs) op_a_q <= bus.wb_data;
                    if (hit_rt) op_b_q <= bus.wb_data;
                    if (bus.op_ready) begin
                        op_valid_q  <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rf_raddr  = rf_raddr_q;
    assign bus.op_valid  = op_valid_q;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.busy      = busy_q;

endmodule
